// File: rtl/uart_tx_arbiter_pkg.sv
// rtl/uart_tx_arbiter_pkg.sv - shared constants for the UART Tx frame arbiter
package uart_tx_arbiter_pkg;

    // FSM state encodings
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HDR  = 3'd1;
    localparam logic [2:0] ST_SEND = 3'd2;
    localparam logic [2:0] ST_GAP  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    // Header byte MSB marks a header, as opposed to a payload byte
    localparam logic HDR_TAG = 1'b1;

    // Source identifiers
    localparam logic SRC_REG = 1'b0;
    localparam logic SRC_USB = 1'b1;

    // One-hot owner vector for a source id
    function automatic logic [1:0] src_onehot(input logic src);
        return (src == SRC_USB) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter2.sv
// rtl/uart_tx_arbiter_rr_arbiter2.sv - two-input round-robin winner select
module rr_arbiter2
    import uart_tx_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_update,
    input  logic i_owner,
    output logic o_valid,
    output logic o_winner
);

    logic r_last_owner;

    // Remember who finished last; reset favours source 0 on the first tie
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last_owner <= SRC_USB;
        end else if (i_update) begin
            r_last_owner <= i_owner;
        end
    end

    // Sole requester wins; on a tie the source that did not go last wins
    always_comb begin
        o_valid  = i_req0 | i_req1;
        o_winner = SRC_REG;
        if (i_req0 && i_req1) begin
            o_winner = ~r_last_owner;
        end else if (i_req1) begin
            o_winner = SRC_USB;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-atomic arbiter for the shared UART Tx FIFO write port
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int LEN_W  = 6,
    parameter int HDR_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [LEN_W-1:0] len0,
    input  logic [LEN_W-1:0] len1,
    input  logic [7:0]       data0,
    input  logic [7:0]       data1,
    input  logic             empty0,
    input  logic             empty1,
    output logic             re0,
    output logic             re1,
    output logic             done0,
    output logic             done1,
    input  logic             UART_Tx_FULL,
    output logic [7:0]       UART_Tx_DATA,
    output logic             UART_send,
    output logic [1:0]       grant,
    output logic             busy
);

    // Header carries six length bits; narrower LEN_W is zero-extended
    localparam int HL = (LEN_W < 6) ? LEN_W : 6;

    logic [2:0]       r_state;
    logic             r_owner;
    logic [LEN_W-1:0] r_len_q;
    logic [LEN_W-1:0] r_cnt;
    logic             r_re0, r_re1, r_done0, r_done1, r_send, r_busy;
    logic [7:0]       r_data;
    logic [1:0]       r_grant;

    logic             w_arb_valid;
    logic             w_winner;
    logic [LEN_W-1:0] w_len_sel;
    logic [7:0]       w_data;
    logic             w_empty;
    logic [5:0]       w_hdr_len;
    logic [7:0]       w_hdr;
    logic [1:0]       w_owner_oh;

    rr_arbiter2 u_rr (
        .clk      (clk),
        .rst      (rst),
        .i_req0   (req0),
        .i_req1   (req1),
        .i_update (r_state == ST_DONE),
        .i_owner  (r_owner),
        .o_valid  (w_arb_valid),
        .o_winner (w_winner)
    );

    assign w_len_sel  = (w_winner == SRC_USB) ? len1 : len0;
    assign w_data     = (r_owner == SRC_USB) ? data1 : data0;
    assign w_empty    = (r_owner == SRC_USB) ? empty1 : empty0;
    assign w_hdr_len  = 6'(r_len_q[HL-1:0]);
    assign w_hdr      = {HDR_TAG, r_owner, w_hdr_len};
    assign w_owner_oh = src_onehot(r_owner);

    // Frame FSM: grant, optional header, byte/gap drain, done pulse
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_owner <= SRC_REG;
            r_len_q <= '0;
            r_cnt   <= '0;
            r_re0   <= 1'b0;
            r_re1   <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_send  <= 1'b0;
            r_data  <= 8'h00;
            r_grant <= 2'b00;
            r_busy  <= 1'b0;
        end else begin
            r_send  <= 1'b0;
            r_re0   <= 1'b0;
            r_re1   <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_arb_valid) begin
                        r_owner <= w_winner;
                        r_grant <= src_onehot(w_winner);
                        r_busy  <= 1'b1;
                        r_len_q <= w_len_sel;
                        r_cnt   <= '0;
                        if (HDR_EN != 0) begin
                            r_state <= ST_HDR;
                        end else if (w_len_sel == '0) begin
                            r_state            <= ST_DONE;
                            {r_done1, r_done0} <= src_onehot(w_winner);
                        end else begin
                            r_state <= ST_SEND;
                        end
                    end
                end
                ST_HDR: begin
                    if (!UART_Tx_FULL) begin
                        r_send <= 1'b1;
                        r_data <= w_hdr;
                        if (r_len_q == '0) begin
                            r_state            <= ST_DONE;
                            {r_done1, r_done0} <= w_owner_oh;
                        end else begin
                            r_state <= ST_SEND;
                        end
                    end
                end
                ST_SEND: begin
                    if (!UART_Tx_FULL && !w_empty) begin
                        r_data  <= w_data;
                        r_send  <= 1'b1;
                        r_re0   <= w_owner_oh[0];
                        r_re1   <= w_owner_oh[1];
                        r_cnt   <= r_cnt + 1'b1;
                        r_state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (r_cnt == r_len_q) begin
                        r_state            <= ST_DONE;
                        {r_done1, r_done0} <= w_owner_oh;
                    end else begin
                        r_state <= ST_SEND;
                    end
                end
                ST_DONE: begin
                    r_grant <= 2'b00;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_grant <= 2'b00;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign re0          = r_re0;
    assign re1          = r_re1;
    assign done0        = r_done0;
    assign done1        = r_done1;
    assign UART_Tx_DATA = r_data;
    assign UART_send    = r_send;
    assign grant        = r_grant;
    assign busy         = r_busy;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [5:0] len0 = 6'd0, len1 = 6'd0;
    logic [7:0] data0, data1;
    logic       empty0, empty1;
    logic       re0, re1, done0, done1;
    logic       full = 1'b0;
    logic [7:0] tx_data;
    logic       tx_send;
    logic [1:0] grant;
    logic       busy;

    logic       hold0 = 1'b0;
    logic [7:0] mem0 [0:31];
    logic [7:0] mem1 [0:31];
    int         wr0 = 0, wr1 = 0;
    int         rd0 = 0, rd1 = 0;

    logic [7:0] cap [0:127];
    int         n_send = 0, n_re0 = 0, n_re1 = 0, n_done0 = 0, n_done1 = 0, n_both = 0;

    int         tests = 0, fails = 0;

    uart_tx_arbiter #(.LEN_W(6), .HDR_EN(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .req0         (req0),
        .req1         (req1),
        .len0         (len0),
        .len1         (len1),
        .data0        (data0),
        .data1        (data1),
        .empty0       (empty0),
        .empty1       (empty1),
        .re0          (re0),
        .re1          (re1),
        .done0        (done0),
        .done1        (done1),
        .UART_Tx_FULL (full),
        .UART_Tx_DATA (tx_data),
        .UART_send    (tx_send),
        .grant        (grant),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    assign data0  = mem0[rd0[4:0]];
    assign data1  = mem1[rd1[4:0]];
    assign empty0 = (rd0 == wr0) || hold0;
    assign empty1 = (rd1 == wr1);

    always @(negedge clk) begin
        if (tx_send) begin
            cap[n_send[6:0]] = tx_data;
            n_send++;
        end
        if (re0) begin rd0++; n_re0++; end
        if (re1) begin rd1++; n_re1++; end
        if (re0 && re1) n_both++;
        if (done0) n_done0++;
        if (done1) n_done1++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push0(input logic [7:0] b);
        mem0[wr0[4:0]] = b;
        wr0++;
    endtask

    task automatic push1(input logic [7:0] b);
        mem1[wr1[4:0]] = b;
        wr1++;
    endtask

    task automatic wait_grant(input string tag, input logic [1:0] g);
        for (int k = 0; k < 60 && grant !== g; k++) tick();
        check(tag, grant, g);
    endtask

    task automatic wait_sends(input string tag, input int target);
        for (int k = 0; k < 200 && n_send < target; k++) tick();
        check(tag, n_send, target);
    endtask

    task automatic wait_done0(input string tag, input int target);
        for (int k = 0; k < 200 && n_done0 < target; k++) tick();
        check(tag, n_done0, target);
    endtask

    task automatic wait_done1(input string tag, input int target);
        for (int k = 0; k < 200 && n_done1 < target; k++) tick();
        check(tag, n_done1, target);
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        int b, s0, r0, r1, d0;

        // Reset held with a pending request, then single frame 81/CA
        rst  = 1'b0;
        req0 = 1'b1;
        len0 = 6'd1;
        push0(8'hCA);
        tick();
        tick();
        check("rst_grant", grant, 2'b00);
        check("rst_busy", busy, 1'b0);
        check("rst_send", tx_send, 1'b0);
        check("rst_data", tx_data, 8'h00);
        check("rst_re", {re1, re0}, 2'b00);
        check("rst_done", {done1, done0}, 2'b00);
        check("rst_re_cnt", n_re0 + n_re1, 0);
        b    = n_send;
        rst  = 1'b1;
        tick();
        check("grant_latency", grant, 2'b01);
        check("busy_after_grant", busy, 1'b1);
        req0 = 1'b0;
        wait_done0("single_done0", 1);
        check("single_nsend", n_send - b, 2);
        check("single_hdr", cap[b], 8'h81);
        check("single_pay", cap[b+1], 8'hCA);
        check("single_re0", n_re0, 1);
        tick();
        check("single_grant_idle", grant, 2'b00);
        check("single_busy_idle", busy, 1'b0);

        // Tie after reset: source 0 first, then source 1, zero-length frames
        req0 = 1'b1;
        req1 = 1'b1;
        len0 = 6'd0;
        len1 = 6'd0;
        s0   = n_done0;
        reset_pulse();
        b    = n_send;
        wait_grant("tie_first", 2'b01);
        wait_grant("tie_second", 2'b10);
        req0 = 1'b0;
        req1 = 1'b0;
        wait_done1("tie_done1", 1);
        tick();
        tick();
        check("tie_nsend", n_send - b, 2);
        check("tie_hdr0", cap[b], 8'h80);
        check("tie_hdr1", cap[b+1], 8'hC0);
        check("tie_done0", n_done0 - s0, 1);

        // Back-pressure on source 1: FULL for 4 cycles during payload
        len1 = 6'd3;
        push1(8'hAC);
        push1(8'hBC);
        push1(8'hCC);
        b    = n_send;
        r1   = n_re1;
        req1 = 1'b1;
        wait_grant("bp_grant", 2'b10);
        req1 = 1'b0;
        wait_sends("bp_first", b + 2);
        full = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        check("bp_stall", n_send - b, 2);
        full = 1'b0;
        wait_done1("bp_done1", 2);
        check("bp_nsend", n_send - b, 4);
        check("bp_hdr", cap[b], 8'hC3);
        check("bp_b0", cap[b+1], 8'hAC);
        check("bp_b1", cap[b+2], 8'hBC);
        check("bp_b2", cap[b+3], 8'hCC);
        check("bp_re1", n_re1 - r1, 3);

        // Source 0 starvation mid-frame
        len0 = 6'd3;
        push0(8'h11);
        push0(8'h22);
        push0(8'h33);
        b    = n_send;
        r0   = n_re0;
        r1   = n_re1;
        d0   = n_done0;
        tick();
        req0 = 1'b1;
        wait_grant("st_grant", 2'b01);
        req0 = 1'b0;
        wait_sends("st_first", b + 2);
        hold0 = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        check("st_stall", n_send - b, 2);
        check("st_no_early_done", n_done0 - d0, 0);
        check("st_busy_hold", busy, 1'b1);
        hold0 = 1'b0;
        wait_done0("st_done0", d0 + 1);
        check("st_hdr", cap[b], 8'h83);
        check("st_b0", cap[b+1], 8'h11);
        check("st_b1", cap[b+2], 8'h22);
        check("st_b2", cap[b+3], 8'h33);
        check("st_re0", n_re0 - r0, 3);
        check("st_no_re1", n_re1 - r1, 0);

        // Reset mid-frame, then fresh frame with a new header
        push0(8'h44);
        push0(8'h55);
        push0(8'h66);
        b    = n_send;
        tick();
        tick();
        req0 = 1'b1;
        wait_sends("mr_first", b + 2);
        check("mr_pay0", cap[b+1], 8'h44);
        rst = 1'b0;
        tick();
        check("mr_grant", grant, 2'b00);
        check("mr_busy", busy, 1'b0);
        check("mr_send", tx_send, 1'b0);
        check("mr_data", tx_data, 8'h00);
        check("mr_re", {re1, re0}, 2'b00);
        tick();
        push0(8'h77);
        d0  = n_done0;
        b   = n_send;
        rst = 1'b1;
        tick();
        check("mr_regrant", grant, 2'b01);
        req0 = 1'b0;
        wait_done0("mr_done0", d0 + 1);
        check("mr_nsend", n_send - b, 4);
        check("mr_hdr", cap[b], 8'h83);
        check("mr_b0", cap[b+1], 8'h55);
        check("mr_b1", cap[b+2], 8'h66);
        check("mr_b2", cap[b+3], 8'h77);

        check("re_exclusive", n_both, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
